reg_file_2r1w: RTL and testbench

//  Parametrised successor to the single-port register file. Provides 2 registered read ports and 1 write port.
//  Has an optional hardwired-zero entry and a hardware clear sequencer that zeroes every entry after reset.

---
 rtl/reg_file_2r1w.sv | 117 +++++++++++
 tb/tb_reg_file_2r1w.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file that zeroes every entry in hardware after reset.
// Reads take 1 cycle (registered outputs); writes land on the clock edge; optional hardwired-zero entry 0.
// No backpressure: ready_o stays low while the clear sequence runs, and all requests are ignored during that time.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_data0_q, rd_data1_q;
    logic                ready_q;

    // Shared storage write port: the clear sequencer owns it in CLEAR, the user port in RUN
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_d;
    logic [DATA_W-1:0]   mem_wdata_d;

    // Next read values for each port (hardwired zero first, then optional forwarding, then storage)
    logic [DATA_W-1:0]   rd_data0_d, rd_data1_d;

    // Select who drives the storage write port this cycle
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = clr_cnt_q;
        mem_wdata_d = '0;
        if (state_q == ST_CLEAR) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clr_cnt_q;
            mem_wdata_d = '0;
        end else begin
            mem_we_d    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
            mem_waddr_d = wr_addr;
            mem_wdata_d = wr_data;
        end
    end

    // Resolve the value each read port would capture on this edge
    always_comb begin
        rd_data0_d = mem_q[rd_addr0];
        rd_data1_d = mem_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr0)) rd_data0_d = wr_data;
        if (wr_en && (wr_addr == rd_addr1)) rd_data1_d = wr_data;
`endif
        if ((ZERO_REG != 0) && (rd_addr0 == '0)) rd_data0_d = '0;
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1_d = '0;
    end

    // Storage array; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Clear/run sequencer with registered read data and ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            rd_data0_q <= '0;
            rd_data1_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rd_data0_q <= '0;
                    rd_data1_q <= '0;
                    clr_cnt_q  <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rd_en0) rd_data0_q <= rd_data0_d;
                    if (rd_en1) rd_data1_q <= rd_data1_d;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data0 = rd_data0_q;
    assign rd_data1 = rd_data1_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed checks of the 2R1W register file: clear sequence, reads, writes, zero entry, forwarding, reset abort.
// Two instances share stimulus: default ZERO_REG=1 and ZERO_REG=0.
// Inputs driven 1ns after posedge, outputs sampled at that point (well away from the next edge).
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;
    logic        rd_en0, rd_en1, wr_en;
    logic [4:0]  rd_addr0, rd_addr1, wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data0, rd_data1, rd_data0_nz, rd_data1_nz;
    logic        ready, ready_nz;

    int tests = 0;
    int fails = 0;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready)
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(rd_data0_nz),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1_nz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en0 = 1'b0; rd_en1 = 1'b0; wr_en = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a0, input logic [4:0] a1);
        idle();
        rd_en0 = 1'b1; rd_addr0 = a0;
        rd_en1 = 1'b1; rd_addr1 = a1;
        tick();
        idle();
    endtask

    initial begin
        int ready_errs;
        int data_errs;
        logic [31:0] exp_byp;

        rst = 1'b1;
        rd_en0 = 1'b0; rd_en1 = 1'b0; wr_en = 1'b0;
        rd_addr0 = '0; rd_addr1 = '0; wr_addr = '0; wr_data = '0;

        // 1. reset held 3 cycles, then 32-edge clear (requests driven during clear are ignored)
        repeat (3) tick();
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rd0", rd_data0, 32'd0);
        check("reset_rd1", rd_data1, 32'd0);
        rst = 1'b0;
        rd_en0 = 1'b1; rd_en1 = 1'b1; rd_addr0 = 5'd4; rd_addr1 = 5'd9;
        ready_errs = 0;
        data_errs = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (ready !== (k == 32)) ready_errs++;
            if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) data_errs++;
        end
        idle();
        check("clear_ready_timing", 32'(ready_errs), 32'd0);
        check("clear_rd_zero", 32'(data_errs), 32'd0);
        check("ready_after_clear", {31'd0, ready}, 32'd1);
        check("ready_after_clear_nz", {31'd0, ready_nz}, 32'd1);
        do_read(5'd12, 5'd31);
        check("cleared_entry12", rd_data0, 32'd0);
        check("cleared_entry31", rd_data1, 32'd0);

        // 2. write then read same address on both ports
        do_write(5'd5, 32'hDEADBEEF);
        do_read(5'd5, 5'd5);
        check("rd0_addr5", rd_data0, 32'hDEADBEEF);
        check("rd1_addr5", rd_data1, 32'hDEADBEEF);

        // 3. hardwired-zero entry vs ordinary entry 0
        do_write(5'd0, 32'h12345678);
        do_read(5'd0, 5'd0);
        check("zero_reg_rd0", rd_data0, 32'h0);
        check("zero_reg_rd1", rd_data1, 32'h0);
        check("nz_entry0_rd0", rd_data0_nz, 32'h12345678);

        // 4. same-cycle write and read of addr 7 (holds 1)
        do_write(5'd7, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_en0 = 1'b1; rd_addr0 = 5'd7;
        rd_en1 = 1'b1; rd_addr1 = 5'd5;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h00000001;
`endif
        check("same_cycle_rd0", rd_data0, exp_byp);
        check("same_cycle_rd1_other", rd_data1, 32'hDEADBEEF);
        do_read(5'd7, 5'd7);
        check("after_write_rd0", rd_data0, 32'hA5A5A5A5);

        // 5. reset in RUN aborts; writes during reset/clear are dropped
        do_write(5'd3, 32'hFF);
        do_read(5'd3, 5'd3);
        check("addr3_ff", rd_data0, 32'hFF);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        tick();
        check("rst_run_ready", {31'd0, ready}, 32'd0);
        check("rst_run_rd0", rd_data0, 32'd0);
        rst = 1'b0;
        wr_data = 32'h55;
        ready_errs = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (ready !== (k == 32)) ready_errs++;
        end
        idle();
        check("reclear_ready_timing", 32'(ready_errs), 32'd0);
        do_read(5'd3, 5'd5);
        check("addr3_after_clear", rd_data0, 32'd0);
        check("addr5_after_clear", rd_data1, 32'd0);

        // 6. hold with rd_en0=0 while address moves; top-address write
        do_write(5'd9, 32'hCAFE0009);
        do_write(5'd31, 32'h31313131);
        do_read(5'd9, 5'd31);
        check("rd0_addr9", rd_data0, 32'hCAFE0009);
        check("rd1_addr31", rd_data1, 32'h31313131);
        rd_en0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_addr0 = 5'(k * 7 + 1);
            tick();
        end
        check("rd0_hold", rd_data0, 32'hCAFE0009);
        check("rd1_hold", rd_data1, 32'h31313131);
        do_read(5'd31, 5'd9);
        check("rd0_addr31", rd_data0, 32'h31313131);
        check("rd1_addr9", rd_data1, 32'hCAFE0009);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
